// File: rtl/ex_alu_stage.sv
// Single-entry execute stage: registers one decoded ALU op, computes the result, valid/ready to EX/MEM.
// Optional feature macro EX_OVERFLOW_TRAP_EN: signed add/sub overflow flag suppresses write-back.
module ex_alu_stage #(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        ALU_Func,
  input  logic [WIDTH-1:0]  operand_a,
  input  logic [WIDTH-1:0]  operand_b,
  input  logic [REG_AW-1:0] dest_reg_in,
  input  logic              reg_write_in,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  alu_result,
  output logic              zero,
  output logic [REG_AW-1:0] dest_reg_out,
  output logic              reg_write_out,
  output logic              illegal_func,
  output logic              overflow,
  output logic [CNT_W-1:0]  retired_cnt
);
  typedef struct packed {
    logic [WIDTH-1:0]  res;
    logic [REG_AW-1:0] rd;
    logic              wr;
    logic              ill;
    logic              ovf;
  } ex_rsp_t;

  logic             accept, handoff;
  logic [WIDTH-1:0] sum, diff;
  ex_rsp_t          rsp_d, rsp_q;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;
  assign handoff  = out_valid && out_ready;
  assign sum      = operand_a + operand_b;
  assign diff     = operand_a - operand_b;

  always_comb begin
    rsp_d     = '0;
    rsp_d.rd  = dest_reg_in;
    case (ALU_Func)
      4'b0100: begin
        rsp_d.res = sum;
`ifdef EX_OVERFLOW_TRAP_EN
        rsp_d.ovf = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) &&
                    (sum[WIDTH-1] != operand_a[WIDTH-1]);
`endif
      end
      4'b1100: begin
        rsp_d.res = diff;
`ifdef EX_OVERFLOW_TRAP_EN
        // B is effectively inverted for subtraction, so operand signs must differ
        rsp_d.ovf = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) &&
                    (diff[WIDTH-1] != operand_a[WIDTH-1]);
`endif
      end
      4'b0000: rsp_d.res = operand_a & operand_b;
      4'b0001: rsp_d.res = operand_a | operand_b;
      4'b0010: rsp_d.res = operand_a ^ operand_b;
      4'b0011: rsp_d.res = ~(operand_a ^ operand_b);
      4'b1101: rsp_d.res = {{(WIDTH-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
      default: rsp_d.ill = 1'b1;
    endcase
    rsp_d.wr = reg_write_in && !rsp_d.ill && !rsp_d.ovf;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid   <= 1'b0;
      rsp_q       <= '0;
      retired_cnt <= '0;
    end else begin
      if (flush)        out_valid <= 1'b0;
      else if (accept)  out_valid <= 1'b1;
      else if (handoff) out_valid <= 1'b0;
      if (accept) rsp_q <= rsp_d;
      // a flushed op is killed, never counted even if downstream was ready
      if (handoff && !flush && !(&retired_cnt))
        retired_cnt <= retired_cnt + CNT_W'(1);
    end
  end

  assign alu_result    = rsp_q.res;
  assign zero          = (rsp_q.res == '0);
  assign dest_reg_out  = rsp_q.rd;
  assign reg_write_out = rsp_q.wr;
  assign illegal_func  = rsp_q.ill;
  assign overflow      = rsp_q.ovf;
endmodule

// File: tb/tb_ex_alu_stage.sv
// Directed + random bench for ex_alu_stage against an arithmetic reference model.
module tb_ex_alu_stage;
  logic        clk = 1'b0, reset_n = 1'b0;
  logic        in_valid = 0, in_ready, flush = 0, out_valid, out_ready = 0;
  logic [3:0]  ALU_Func = 0;
  logic [31:0] operand_a = 0, operand_b = 0, alu_result;
  logic [4:0]  dest_reg_in = 0, dest_reg_out;
  logic        reg_write_in = 0, zero, reg_write_out, illegal_func, overflow;
  logic [15:0] retired_cnt;

  int nchk = 0, nerr = 0;

  // model state
  logic        m_valid;
  logic [31:0] m_res;
  logic [4:0]  m_rd;
  logic        m_wr, m_ill, m_ovf;
  int          m_cnt;

  ex_alu_stage dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .ALU_Func(ALU_Func), .operand_a(operand_a), .operand_b(operand_b),
    .dest_reg_in(dest_reg_in), .reg_write_in(reg_write_in), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .alu_result(alu_result),
    .zero(zero), .dest_reg_out(dest_reg_out), .reg_write_out(reg_write_out),
    .illegal_func(illegal_func), .overflow(overflow), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Result computed with wide signed arithmetic, not bit tricks
  task automatic alu_ref(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic ill, output logic ovf);
    longint sa, sb, wide;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = 0; ill = 0; wide = 0;
    case (f)
      4'h4: begin wide = sa + sb; r = a + b; end
      4'hC: begin wide = sa - sb; r = a - b; end
      4'h0: r = a & b;
      4'h1: r = a | b;
      4'h2: r = a ^ b;
      4'h3: r = ~(a ^ b);
      4'hD: r = (sa < sb) ? 32'd1 : 32'd0;
      default: ill = 1;
    endcase
`ifdef EX_OVERFLOW_TRAP_EN
    ovf = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
`else
    ovf = 0;
`endif
  endtask

  task automatic model_reset();
    m_valid = 0; m_res = 0; m_rd = 0; m_wr = 0; m_ill = 0; m_ovf = 0; m_cnt = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
    chk({tag, ".result"},    alu_result, m_res);
    chk({tag, ".zero"},      32'(zero), 32'(m_res == 0));
    chk({tag, ".dest"},      32'(dest_reg_out), 32'(m_rd));
    chk({tag, ".wr"},        32'(reg_write_out), 32'(m_wr));
    chk({tag, ".ill"},       32'(illegal_func), 32'(m_ill));
    chk({tag, ".ovf"},       32'(overflow), 32'(m_ovf));
    chk({tag, ".cnt"},       32'(retired_cnt), 32'(m_cnt));
  endtask

  // One clock: check in_ready, advance model by the stage rules, check outputs after the edge
  task automatic cyc(input string tag, input bit do_chk);
    logic rdy, hand, ill, ovf;
    logic [31:0] r;
    #1;
    rdy  = !m_valid || out_ready;
    hand = m_valid && out_ready;
    if (do_chk) chk({tag, ".in_ready"}, 32'(in_ready), 32'(rdy));
    if (flush) m_valid = 0;
    else if (in_valid && rdy) begin
      alu_ref(ALU_Func, operand_a, operand_b, r, ill, ovf);
      m_valid = 1; m_res = r; m_rd = dest_reg_in; m_ill = ill; m_ovf = ovf;
      m_wr = reg_write_in && !ill && !ovf;
    end else if (hand) m_valid = 0;
    if (hand && !flush && m_cnt < 65535) m_cnt++;
    @(posedge clk); #1;
    if (do_chk) check_all(tag);
  endtask

  task automatic drive(input logic v, input logic [3:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic rw);
    in_valid = v; ALU_Func = f; operand_a = a; operand_b = b;
    dest_reg_in = rd; reg_write_in = rw;
  endtask

  initial begin
    model_reset();
    #12;
    chk("reset.in_ready", 32'(in_ready), 32'd1);
    check_all("reset");
    reset_n = 1;
    @(posedge clk); #1;

    // 2: add overflow boundary
    out_ready = 1;
    drive(1, 4'h4, 32'h7FFF_FFFF, 32'h1, 5'd3, 1);
    cyc("add_ovf", 1);
    chk("add_ovf.value", alu_result, 32'h8000_0000);
`ifdef EX_OVERFLOW_TRAP_EN
    chk("add_ovf.trap_wr", 32'(reg_write_out), 32'd0);
`else
    chk("add_ovf.addu_wr", 32'(reg_write_out), 32'd1);
`endif

    // 3: sub to zero, signed slt
    drive(1, 4'hC, 32'd5, 32'd5, 5'd4, 1);
    cyc("sub_zero", 1);
    chk("sub_zero.zero", 32'(zero), 32'd1);
    drive(1, 4'hD, 32'hFFFF_FFFF, 32'd1, 5'd5, 1);
    cyc("slt", 1);
    chk("slt.value", alu_result, 32'd1);

    // 4: stall three cycles while another op is offered
    drive(1, 4'h2, 32'hF0, 32'hFF, 5'd6, 1);
    cyc("xor", 1);
    out_ready = 0;
    drive(1, 4'h0, 32'h1234, 32'hFFFF, 5'd7, 1);
    for (int i = 0; i < 3; i++) cyc("stall", 1);
    chk("stall.value", alu_result, 32'h0F);
    chk("stall.in_ready", 32'(in_ready), 32'd0);
    out_ready = 1;
    in_valid = 0;
    cyc("release", 1);

    // 5: flush while held and offered
    drive(1, 4'h1, 32'hA, 32'h5, 5'd8, 1);
    out_ready = 0;
    cyc("load", 1);
    flush = 1;
    drive(1, 4'h4, 32'd100, 32'd200, 5'd9, 1);
    cyc("flush", 1);
    flush = 0; in_valid = 0; out_ready = 1;
    cyc("post_flush", 1);

    // 6: illegal code
    drive(1, 4'hF, 32'hDEAD, 32'hBEEF, 5'd10, 1);
    cyc("illegal", 1);
    chk("illegal.flag", 32'(illegal_func), 32'd1);
    chk("illegal.wr", 32'(reg_write_out), 32'd0);
    in_valid = 0;
    cyc("idle", 1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), $urandom, $urandom,
            5'($urandom), 1'($urandom));
      if (i % 5 == 0) operand_b = operand_a;
      out_ready = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 15) == 0;
      cyc("rand", 1);
    end
    flush = 0;

    // 1: reset mid-stream
    drive(1, 4'h4, 32'd1, 32'd2, 5'd1, 1);
    cyc("pre_rst", 1);
    #2 reset_n = 0;
    #1 model_reset();
    chk("midrst.in_ready", 32'(in_ready), 32'd1);
    check_all("midrst");
    in_valid = 0;
    @(posedge clk); #2 reset_n = 1;
    @(posedge clk); #1;

    // saturate counter with back-to-back handoffs
    out_ready = 1;
    drive(1, 4'h1, 32'h1, 32'h2, 5'd2, 1);
    for (int i = 0; i < 65540; i++) cyc("sat_run", 0);
    check_all("sat");
    chk("sat.cnt_max", 32'(retired_cnt), 32'h0000_FFFF);
    cyc("sat_hold", 1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
